// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave register file.
// Contents:
//   spi_state_t - frame FSM states (IDLE, ADDR, DATA, DONE)
//   frame_bits  - total frame length in bits (address phase + data phase)
//   wr_flag_pos - bit position of the write flag within the address word
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_t;

  function automatic int unsigned frame_bits(input int unsigned address_width,
                                             input int unsigned data_width);
    return address_width + data_width;
  endfunction

  function automatic int unsigned wr_flag_pos(input int unsigned address_width);
    return address_width - 1;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Pin conditioning for the SPI slave: 2-FF synchronizers on SCK, SS and MOSI,
// plus registered edge strobes. Every strobe appears 3 clocks after the pin moves.
// Ports:
//   clock, reset    - local clock, synchronous active-high reset
//   clock_polarity  - CPOL, classifies SCK edges as leading or trailing
//   sck, ss, mosi   - raw asynchronous SPI pins
//   ss_level        - synchronized SS level
//   ss_fall/ss_rise - one-cycle SS edge strobes
//   mosi_sync       - synchronized MOSI, aligned with the SCK strobes
//   lead/trail      - one-cycle strobes for SCK leaving / returning to CPOL
module spi_pin_sync (
  input  logic clock,
  input  logic reset,
  input  logic clock_polarity,
  input  logic sck,
  input  logic ss,
  input  logic mosi,
  output logic ss_level,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_sync,
  output logic lead,
  output logic trail
);

  logic sck_meta, sck_sync, sck_dly;
  logic ss_meta, ss_sync, ss_dly;
  logic mosi_meta, mosi_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_dly   <= 1'b0;
      ss_meta   <= 1'b0;
      ss_sync   <= 1'b0;
      ss_dly    <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
      mosi_sync <= 1'b0;
      lead      <= 1'b0;
      trail     <= 1'b0;
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
    end else begin
      sck_meta  <= sck;
      sck_sync  <= sck_meta;
      sck_dly   <= sck_sync;
      ss_meta   <= ss;
      ss_sync   <= ss_meta;
      ss_dly    <= ss_sync;
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
      mosi_sync <= mosi_s;
      lead      <= (sck_sync != sck_dly) && (sck_sync != clock_polarity);
      trail     <= (sck_sync != sck_dly) && (sck_sync == clock_polarity);
      ss_fall   <= ss_dly && !ss_sync;
      ss_rise   <= !ss_dly && ss_sync;
    end
  end

  assign ss_level = ss_dly;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave endpoint backed by a 2^REG_ADDR_BITS x DATA_WIDTH register file.
// Frame: ADDRESS_WIDTH address bits (MSB = write flag) then DATA_WIDTH data
// bits, MSB first. Pins are oversampled in the local clock domain.
// Ports:
//   clock, reset                - system clock, synchronous active-high reset
//   clock_polarity, clock_phase - CPOL/CPHA, static while SS is low
//   SCK, SS, MOSI               - asynchronous SPI inputs (SS active low)
//   MISO                        - slave data out, 0 outside read data phase
//   busy                        - high while a frame is in progress
//   wr_valid, wr_index, wr_data - committed write pulse and held write info
//   frame_error                 - pulse on abort or extra SCK edges
//   local_index, local_data     - combinational local read port
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clock_polarity,
  input  logic                     clock_phase,
  input  logic                     SCK,
  input  logic                     SS,
  input  logic                     MOSI,
  output logic                     MISO,
  output logic                     busy,
  output logic                     wr_valid,
  output logic [REG_ADDR_BITS-1:0] wr_index,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     frame_error,
  input  logic [REG_ADDR_BITS-1:0] local_index,
  output logic [DATA_WIDTH-1:0]    local_data
);

  localparam int unsigned NUM_REGS = 1 << REG_ADDR_BITS;
  localparam int unsigned CNT_W    = $clog2(frame_bits(ADDRESS_WIDTH, DATA_WIDTH));
  localparam int unsigned WR_FLAG  = wr_flag_pos(ADDRESS_WIDTH);

  logic ss_level, ss_fall, ss_rise, mosi_s, lead, trail;

  spi_pin_sync u_pin_sync (
    .clock          (clock),
    .reset          (reset),
    .clock_polarity (clock_polarity),
    .sck            (SCK),
    .ss             (SS),
    .mosi           (MOSI),
    .ss_level       (ss_level),
    .ss_fall        (ss_fall),
    .ss_rise        (ss_rise),
    .mosi_sync      (mosi_s),
    .lead           (lead),
    .trail          (trail)
  );

  // CPHA selects which edge samples MOSI and which one advances MISO.
  logic sample_edge, shift_edge;
  assign sample_edge = clock_phase ? trail : lead;
  assign shift_edge  = clock_phase ? lead  : trail;

  spi_state_t                  state;
  logic                        armed;
  logic                        is_write;
  logic                        last_sampled;
  logic                        extra_edges;
  logic [CNT_W-1:0]            bit_cnt;
  logic [REG_ADDR_BITS-1:0]    index;
  logic [ADDRESS_WIDTH-2:0]    addr_sr;
  logic [DATA_WIDTH-2:0]       data_sr;
  logic [DATA_WIDTH-1:0]       miso_sr;
  logic                        miso_q;
  logic [DATA_WIDTH-1:0]       regs [NUM_REGS];

  logic [ADDRESS_WIDTH-1:0]    addr_next;
  logic [DATA_WIDTH-1:0]       data_next;
  logic [REG_ADDR_BITS-1:0]    addr_index;
  assign addr_next  = {addr_sr, mosi_s};
  assign data_next  = {data_sr, mosi_s};
  assign addr_index = addr_next[REG_ADDR_BITS-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      armed        <= 1'b0;
      is_write     <= 1'b0;
      last_sampled <= 1'b0;
      extra_edges  <= 1'b0;
      bit_cnt      <= '0;
      index        <= '0;
      addr_sr      <= '0;
      data_sr      <= '0;
      miso_sr      <= '0;
      miso_q       <= 1'b0;
      busy         <= 1'b0;
      wr_valid     <= 1'b0;
      wr_index     <= '0;
      wr_data      <= '0;
      frame_error  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_valid    <= 1'b0;
      frame_error <= 1'b0;
      if (ss_level) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (ss_fall && armed) begin
            state        <= ST_ADDR;
            bit_cnt      <= '0;
            busy         <= 1'b1;
            is_write     <= 1'b0;
            last_sampled <= 1'b0;
            extra_edges  <= 1'b0;
            miso_q       <= 1'b0;
          end
        end

        ST_ADDR: begin
          if (ss_rise) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
            miso_q      <= 1'b0;
          end else if (sample_edge) begin
            addr_sr <= addr_next[ADDRESS_WIDTH-2:0];
            if (bit_cnt == CNT_W'(ADDRESS_WIDTH - 1)) begin
              state    <= ST_DATA;
              bit_cnt  <= '0;
              is_write <= addr_next[WR_FLAG];
              index    <= addr_index;
              if (addr_next[WR_FLAG]) begin
                miso_q  <= 1'b0;
                miso_sr <= '0;
              end else if (!clock_phase) begin
                // CPHA=0: master samples the MSB on the very next leading edge.
                miso_q  <= regs[addr_index][DATA_WIDTH-1];
                miso_sr <= regs[addr_index] << 1;
              end else begin
                // CPHA=1: the MSB goes out on the first data leading edge.
                miso_q  <= 1'b0;
                miso_sr <= regs[addr_index];
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        ST_DATA: begin
          if (ss_rise) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
            miso_q      <= 1'b0;
          end else if (sample_edge && !last_sampled) begin
            data_sr <= data_next[DATA_WIDTH-2:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              if (is_write) begin
                regs[index] <= data_next;
                wr_valid    <= 1'b1;
                wr_index    <= index;
                wr_data     <= data_next;
              end
              // With CPHA=0 the frame's final trailing edge is still to come;
              // wait for it so it is not counted as an extra edge in DONE.
              if (clock_phase) begin
                state  <= ST_DONE;
                miso_q <= 1'b0;
              end else begin
                last_sampled <= 1'b1;
              end
            end
          end else if (shift_edge) begin
            if (last_sampled) begin
              state  <= ST_DONE;
              miso_q <= 1'b0;
            end else if (!is_write && (clock_phase || bit_cnt != '0)) begin
              // CPHA=0: the trailing edge right after the address is skipped,
              // the MSB is already on MISO.
              miso_q  <= miso_sr[DATA_WIDTH-1];
              miso_sr <= miso_sr << 1;
            end
          end
        end

        ST_DONE: begin
          if (lead || trail) extra_edges <= 1'b1;
          if (ss_rise) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            frame_error <= extra_edges;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign MISO       = miso_q;
  assign local_data = regs[local_index];

endmodule

// File: tb/tb_spi_slave_regfile.sv
module tb_spi_slave_regfile;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int RAB  = 4;
  localparam int HALF = 5;

  logic           clock = 1'b0;
  logic           reset;
  logic           cpol, cpha, sck, ss, mosi;
  logic           miso, busy, wr_valid, frame_error;
  logic [RAB-1:0] wr_index, local_index;
  logic [DW-1:0]  wr_data, local_data;

  always #5 clock = ~clock;

  spi_slave_regfile #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .REG_ADDR_BITS (RAB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .clock_polarity (cpol),
    .clock_phase    (cpha),
    .SCK            (sck),
    .SS             (ss),
    .MOSI           (mosi),
    .MISO           (miso),
    .busy           (busy),
    .wr_valid       (wr_valid),
    .wr_index       (wr_index),
    .wr_data        (wr_data),
    .frame_error    (frame_error),
    .local_index    (local_index),
    .local_data     (local_data)
  );

  int total = 0;
  int bad   = 0;

  // Pulse monitor: counts every wr_valid / frame_error cycle.
  int             wr_seen  = 0;
  int             err_seen = 0;
  logic [RAB-1:0] last_idx;
  logic [DW-1:0]  last_data;
  always @(negedge clock) begin
    if (wr_valid) begin
      wr_seen   = wr_seen + 1;
      last_idx  = wr_index;
      last_data = wr_data;
    end
    if (frame_error) err_seen = err_seen + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic peek(input logic [RAB-1:0] idx, output logic [DW-1:0] v);
    local_index = idx;
    #1;
    v = local_data;
  endtask

  // Behavioural master: drives one frame of nbits bits, optional extra SCK
  // cycles after the frame, optional one-clock reset pulse at bit rst_at.
  logic [DW-1:0] rdata;
  logic          end_busy;
  task automatic spi_frame(input logic pol, input logic pha,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int nbits, input int extra, input int rst_at);
    logic [AW+DW-1:0] frame;
    frame    = {addr, data};
    rdata    = '0;
    end_busy = 1'b0;
    cpol = pol; cpha = pha; sck = pol;
    tick(4);
    ss = 1'b0;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_miso", {31'b0, miso}, 32'd0);
      end
      if (!pha) begin
        mosi = frame[AW+DW-1-i];
        tick(HALF);
        if (i >= AW) rdata = {rdata[DW-2:0], miso};
        sck = ~pol;
        tick(HALF);
        sck = pol;
      end else begin
        sck  = ~pol;
        mosi = frame[AW+DW-1-i];
        tick(HALF);
        if (i >= AW) rdata = {rdata[DW-2:0], miso};
        sck = pol;
        tick(HALF);
      end
      if (i == nbits - 1) end_busy = busy;
    end
    for (int e = 0; e < extra; e++) begin
      sck = ~pol; tick(HALF);
      sck = pol;  tick(HALF);
    end
    tick(HALF);
    ss = 1'b1;
    tick(8);
  endtask

  typedef struct {
    logic        pol;
    logic        pha;
    logic [31:0] addr;
    logic [31:0] data;
    int          nbits;
    int          extra;
    logic [31:0] exp_wr;
    logic [31:0] exp_err;
    logic [31:0] exp_rd;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t          vt [15];
  logic [DW-1:0] ref_regs [16];

  initial begin
    int            wr0, err0;
    logic [DW-1:0] v;
    logic [RAB-1:0] idx;

    vt[0]  = '{1'b0, 1'b0, 32'h80000010, 32'hA5A5A5A5, 64, 0, 1, 0, 0, 32'hA5A5A5A5};
    vt[1]  = '{1'b0, 1'b0, 32'h80000005, 32'h12345678, 64, 0, 1, 0, 0, 32'h12345678};
    vt[2]  = '{1'b0, 1'b0, 32'h00000005, 32'h00000000, 64, 0, 0, 0, 32'h12345678, 32'h12345678};
    vt[3]  = '{1'b0, 1'b1, 32'h80000003, 32'hDEADBEEF, 64, 0, 1, 0, 0, 32'hDEADBEEF};
    vt[4]  = '{1'b0, 1'b1, 32'h00000003, 32'h00000000, 64, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[5]  = '{1'b1, 1'b0, 32'h80000003, 32'hDEADBEEF, 64, 0, 1, 0, 0, 32'hDEADBEEF};
    vt[6]  = '{1'b1, 1'b0, 32'h00000003, 32'h00000000, 64, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[7]  = '{1'b1, 1'b1, 32'h80000003, 32'hDEADBEEF, 64, 0, 1, 0, 0, 32'hDEADBEEF};
    vt[8]  = '{1'b1, 1'b1, 32'h00000003, 32'h00000000, 64, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[9]  = '{1'b0, 1'b0, 32'h80000002, 32'hFFFFFFFF, 40, 0, 0, 1, 0, 32'h00000000};
    vt[10] = '{1'b0, 1'b0, 32'hFFFFFFF7, 32'h00000001, 64, 0, 1, 0, 0, 32'h00000001};
    vt[11] = '{1'b1, 1'b1, 32'h00000007, 32'h00000000, 64, 0, 0, 0, 32'h00000001, 32'h00000001};
    vt[12] = '{1'b0, 1'b1, 32'h80000009, 32'h0BADF00D, 64, 2, 1, 1, 0, 32'h0BADF00D};
    vt[13] = '{1'b1, 1'b0, 32'h0000000F, 32'hFFFFFFFF, 64, 0, 0, 0, 32'h00000000, 32'h00000000};
    vt[14] = '{1'b0, 1'b0, 32'h7FFFFFF0, 32'h00000000, 64, 0, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5};

    for (int i = 0; i < 16; i++) ref_regs[i] = '0;

    // Reset state
    reset = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; local_index = '0;
    tick(3);
    check("reset_busy",  {31'b0, busy}, 32'd0);
    check("reset_miso",  {31'b0, miso}, 32'd0);
    check("reset_wrv",   {31'b0, wr_valid}, 32'd0);
    check("reset_ferr",  {31'b0, frame_error}, 32'd0);
    check("reset_wridx", {28'b0, wr_index}, 32'd0);
    check("reset_wrdat", wr_data, 32'd0);
    check("reset_local", local_data, 32'd0);
    reset = 1'b0;
    tick(10);

    // Directed vector table
    for (int r = 0; r < 15; r++) begin
      wr0 = wr_seen; err0 = err_seen;
      spi_frame(vt[r].pol, vt[r].pha, vt[r].addr, vt[r].data, vt[r].nbits, vt[r].extra, -1);
      idx = vt[r].addr[RAB-1:0];
      check($sformatf("vec%0d_wr", r),    wr_seen - wr0, vt[r].exp_wr);
      check($sformatf("vec%0d_err", r),   err_seen - err0, vt[r].exp_err);
      check($sformatf("vec%0d_busy", r),  {31'b0, end_busy}, 32'd1);
      check($sformatf("vec%0d_idle", r),  {31'b0, busy}, 32'd0);
      if (vt[r].nbits == AW + DW)
        check($sformatf("vec%0d_rdata", r), rdata, vt[r].exp_rd);
      if (vt[r].exp_wr != 0) begin
        check($sformatf("vec%0d_wridx", r), {28'b0, last_idx}, {28'b0, idx});
        check($sformatf("vec%0d_wrdat", r), last_data, vt[r].data);
      end
      peek(idx, v);
      check($sformatf("vec%0d_reg", r), v, vt[r].exp_reg);
      if (vt[r].addr[AW-1] && vt[r].nbits == AW + DW) ref_regs[idx] = vt[r].data;
    end

    // Reset pulse at bit 20 with SS held low: frame ignored, file cleared
    wr0 = wr_seen; err0 = err_seen;
    spi_frame(1'b0, 1'b0, 32'h80000004, 32'hCAFEF00D, 64, 0, 20);
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    check("rstmid_wr",   wr_seen - wr0, 32'd0);
    check("rstmid_err",  err_seen - err0, 32'd0);
    check("rstmid_busy", {31'b0, end_busy}, 32'd0);
    peek(4'd4, v);
    check("rstmid_reg4", v, 32'd0);
    peek(4'd5, v);
    check("rstmid_reg5", v, 32'd0);
    wr0 = wr_seen;
    spi_frame(1'b0, 1'b0, 32'h80000004, 32'hCAFEF00D, 64, 0, -1);
    ref_regs[4] = 32'hCAFEF00D;
    check("after_rst_wr", wr_seen - wr0, 32'd1);
    peek(4'd4, v);
    check("after_rst_reg4", v, 32'hCAFEF00D);

    // Randomized frames against the register-array model
    for (int n = 0; n < 25; n++) begin
      logic          pol, pha, op;
      logic [31:0]   up, addr, data;
      logic [DW-1:0] exp_rd;
      int            nb;
      pol  = 1'($urandom_range(0, 1));
      pha  = 1'($urandom_range(0, 1));
      op   = 1'($urandom_range(0, 1));
      idx  = 4'($urandom_range(0, 3));
      up   = $urandom;
      addr = {op, up[30:4], idx};
      data = $urandom;
      nb   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 63)) : 64;
      exp_rd = op ? '0 : ref_regs[idx];
      wr0 = wr_seen; err0 = err_seen;
      spi_frame(pol, pha, addr, data, nb, 0, -1);
      if (op && nb == 64) ref_regs[idx] = data;
      check($sformatf("rnd%0d_wr", n),  wr_seen - wr0, (op && nb == 64) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_err", n), err_seen - err0, (nb != 64) ? 32'd1 : 32'd0);
      if (nb == 64) check($sformatf("rnd%0d_rdata", n), rdata, exp_rd);
      if (op && nb == 64) check($sformatf("rnd%0d_wrdat", n), last_data, data);
      peek(idx, v);
      check($sformatf("rnd%0d_reg", n), v, ref_regs[idx]);
    end

    for (int i = 0; i < 16; i++) begin
      peek(4'(i), v);
      check($sformatf("final_reg%0d", i), v, ref_regs[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
